// File: rtl/wave_capture_pkg.sv
// Shared definitions for the waveform capture stage and the display path:
// FSM state encodings, sample conversion constant and the conversion helper.
package wave_capture_pkg;

   localparam int SAMPLE_W    = 16;
   localparam int NUM_SAMPLES = 256;

   // Capture FSM state encodings (kept as plain constants for legacy users)
   localparam logic [1:0] ST_ARMED  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;

   // Offset of the last sample in a capture
   localparam logic [7:0] LAST_OFFSET = 8'(NUM_SAMPLES - 1);

   // Flipping the sign bit of the high byte maps signed -128..127 onto 0..255
   localparam logic [7:0] SAMPLE_CONV = 8'h80;

   // Convert a signed sample to the unsigned 8-bit value stored in the RAM
   function automatic logic [7:0] sample_to_u8(input logic [SAMPLE_W-1:0] sample);
      return sample[SAMPLE_W-1 -: 8] ^ SAMPLE_CONV;
   endfunction

endpackage

// File: rtl/wave_capture_counter.sv
// 8-bit capture offset counter. Counts written samples and wraps from 255
// to 0, which leaves it at offset 0 ready for the next capture.
module wave_capture_counter (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   output logic [7:0] o_count
);

   logic [7:0] r_count;

   // Advance once per captured sample; synchronous clear on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= 8'd0;
      end else if (i_en) begin
         r_count <= r_count + 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/wave_capture.sv
// Waveform capture stage: arms on a positive-going zero crossing, writes 256
// converted samples into the RAM half the display is not reading, then waits
// for the display to go idle before swapping halves.
module wave_capture
   import wave_capture_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                new_sample_ready,
   input  logic [SAMPLE_W-1:0] new_sample_in,
   input  logic                wave_display_idle,
   output logic [8:0]          write_address,
   output logic                write_enable,
   output logic [7:0]          write_sample,
   output logic                read_index
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_prev_neg;
   logic       r_read_index;
   logic       w_read_index_nxt;
   logic       r_write_enable;
   logic [8:0] r_write_address;
   logic [7:0] r_write_sample;
   logic [7:0] w_count;
   logic       w_crossing;
   logic       w_write;

   // A crossing compares against the sign of the previous strobed sample
   assign w_crossing = new_sample_ready & r_prev_neg & ~new_sample_in[SAMPLE_W-1];

   // Write qualifier: the crossing sample itself in ARMED, every sample in ACTIVE
   always_comb begin
      w_write = 1'b0;
      case (r_state)
         ST_ARMED:  w_write = w_crossing;
         ST_ACTIVE: w_write = new_sample_ready;
         ST_WAIT:   w_write = 1'b0;
         default:   w_write = 1'b0;
      endcase
   end

   wave_capture_counter u_capture_counter (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_write),
      .o_count (w_count)
   );

   // Next-state and buffer-swap decision
   always_comb begin
      w_state_nxt      = r_state;
      w_read_index_nxt = r_read_index;
      case (r_state)
         ST_ARMED: begin
            if (w_crossing) begin
               w_state_nxt = ST_ACTIVE;
            end else begin
               w_state_nxt = ST_ARMED;
            end
         end
         ST_ACTIVE: begin
            if (new_sample_ready && (w_count == LAST_OFFSET)) begin
               w_state_nxt = ST_WAIT;
            end else begin
               w_state_nxt = ST_ACTIVE;
            end
         end
         ST_WAIT: begin
            if (wave_display_idle) begin
               w_state_nxt      = ST_ARMED;
               w_read_index_nxt = ~r_read_index;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         default: begin
            w_state_nxt = ST_ARMED;
         end
      endcase
   end

   // State, buffer select and sign history
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_ARMED;
         r_read_index <= 1'b0;
         r_prev_neg   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_read_index <= w_read_index_nxt;
         if (new_sample_ready) begin
            r_prev_neg <= new_sample_in[SAMPLE_W-1];
         end else begin
            r_prev_neg <= r_prev_neg;
         end
      end
   end

   // Registered RAM write port; address and data hold between writes
   always_ff @(posedge clk) begin
      if (reset) begin
         r_write_enable  <= 1'b0;
         r_write_address <= 9'd0;
         r_write_sample  <= 8'd0;
      end else begin
         r_write_enable <= w_write;
         if (w_write) begin
            r_write_address <= {~r_read_index, w_count};
            r_write_sample  <= sample_to_u8(new_sample_in);
         end else begin
            r_write_address <= r_write_address;
            r_write_sample  <= r_write_sample;
         end
      end
   end

   assign write_enable  = r_write_enable;
   assign write_address = r_write_address;
   assign write_sample  = r_write_sample;
   assign read_index    = r_read_index;

endmodule
